// File: rtl/icache_fill_pkg.sv
// icache_fill_pkg: shared state encoding and line geometry for the I-cache line fill path
package icache_fill_pkg;
  typedef enum logic [1:0] {IDLE, REQ, COLLECT, DRAIN} fill_state_t;
  localparam int LINE_BYTES     = 32;
  localparam int WORDS_PER_BEAT = 2;
  localparam int WORD_IDX_W     = 3;
  localparam int BEAT_IDX_W     = 2;
endpackage

// File: rtl/icache_line_fill_if.sv
// icache_line_fill_if: miss request, burst memory and fill buffer signals of the line fill block
interface icache_line_fill_if #(
  parameter int LINE_WORDS = 8,
  parameter int BEAT_BITS  = 64
);
  logic                     miss_valid;
  logic [31:0]              miss_addr;
  logic                     miss_ready;
  logic                     flush;
  logic [31:0]              bmem_addr;
  logic                     bmem_read;
  logic                     bmem_ready;
  logic [31:0]              bmem_raddr;
  logic [BEAT_BITS-1:0]     bmem_rdata;
  logic                     bmem_rvalid;
  logic                     fill_valid;
  logic [31:0]              fill_addr;
  logic [LINE_WORDS*32-1:0] fill_data;
  logic                     fill_done;
  logic                     busy;
  modport master (
    input  miss_valid, miss_addr, flush, bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output miss_ready, bmem_addr, bmem_read, fill_valid, fill_addr, fill_data, fill_done, busy
  );
  modport slave (
    output miss_valid, miss_addr, flush, bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  miss_ready, bmem_addr, bmem_read, fill_valid, fill_addr, fill_data, fill_done, busy
  );
endinterface

// File: rtl/fill_line_asm.sv
// fill_line_asm: assembles memory beats into the line register and tracks which words have landed
module fill_line_asm
  import icache_fill_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int BEAT_BITS  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr,
  input  logic [BEAT_IDX_W-1:0]    beat_idx,
  input  logic [BEAT_BITS-1:0]     rdata,
  output logic [LINE_WORDS-1:0]    word_valid,
  output logic [LINE_WORDS*32-1:0] line
);
  always_ff @(posedge clk)
    if (rst || clear) word_valid <= '0;
    else if (wr) word_valid[beat_idx*WORDS_PER_BEAT +: WORDS_PER_BEAT] <= '1;
  always_ff @(posedge clk)
    if (wr) line[beat_idx*BEAT_BITS +: BEAT_BITS] <= rdata;
endmodule

// File: rtl/icache_line_fill.sv
// icache_line_fill: bursts a missing line from memory and replays it critical word first to the fetch buffer
module icache_line_fill
  import icache_fill_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int BEAT_BITS  = 64,
  parameter int BURST_LEN  = 4
) (
  input logic clk,
  input logic rst,
  icache_line_fill_if.master bus
);
  localparam int OFS_W = $clog2(LINE_BYTES);
  fill_state_t state, state_n;
  logic [31:0] line_addr;
  logic [WORD_IDX_W-1:0] emit_idx;
  logic [3:0] emit_cnt;
  logic [2:0] beat_cnt;
  logic [LINE_WORDS-1:0] word_valid;
  logic [LINE_WORDS*32-1:0] line;
  logic [31:0] word;
  logic accept, beat, fire, last_word, last_beat, all_beats;
  assign accept    = state == IDLE && bus.miss_valid && !bus.flush;
  assign beat      = state == COLLECT && bus.bmem_rvalid;
  assign fire      = state == COLLECT && !bus.flush && word_valid[emit_idx];
  assign last_word = emit_cnt == 4'(LINE_WORDS - 1);
  assign last_beat = bus.bmem_rvalid && beat_cnt == 3'(BURST_LEN - 1);
  assign all_beats = beat_cnt + 3'(bus.bmem_rvalid) == 3'(BURST_LEN);
  assign word      = line[{emit_idx, 5'b0} +: 32];
  fill_line_asm #(.LINE_WORDS(LINE_WORDS), .BEAT_BITS(BEAT_BITS)) u_asm (
    .clk, .rst, .clear(accept), .wr(beat),
    .beat_idx(bus.bmem_raddr[OFS_W-1 -: BEAT_IDX_W]), .rdata(bus.bmem_rdata),
    .word_valid, .line
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? REQ : IDLE;
      REQ:     state_n = bus.flush ? (bus.bmem_ready ? DRAIN : IDLE) : (bus.bmem_ready ? COLLECT : REQ);
      COLLECT: state_n = bus.flush ? (all_beats ? IDLE : DRAIN) : (fire && last_word ? IDLE : COLLECT);
      DRAIN:   state_n = last_beat ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      line_addr <= '0;
      emit_idx  <= '0;
      emit_cnt  <= '0;
      beat_cnt  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        line_addr <= {bus.miss_addr[31:OFS_W], OFS_W'(0)};
        emit_idx  <= bus.miss_addr[OFS_W-1:2];
        emit_cnt  <= '0;
        beat_cnt  <= '0;
      end
      if (fire) begin
        emit_idx <= emit_idx + 1'b1;
        emit_cnt <= emit_cnt + 1'b1;
      end
      if ((state == COLLECT || state == DRAIN) && bus.bmem_rvalid) beat_cnt <= beat_cnt + 1'b1;
    end
  assign bus.miss_ready = state == IDLE;
  assign bus.busy       = state != IDLE;
  assign bus.bmem_read  = state == REQ;
  assign bus.bmem_addr  = state == REQ ? line_addr : '0;
  assign bus.fill_valid = fire;
  assign bus.fill_done  = fire && last_word;
  assign bus.fill_addr  = fire ? {line_addr[31:OFS_W], emit_idx, 2'b00} : '0;
  assign bus.fill_data  = fire ? {{(LINE_WORDS-1)*32{1'b0}}, word} << {emit_idx, 5'b0} : '0;
  // beats are only meaningful once the burst request has been accepted
  a_no_early_beat: assert property (@(posedge clk) disable iff (rst)
    !((state == IDLE || state == REQ) && bus.bmem_rvalid));
endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Transmitter side of the instruction fetch line-fill interface.
- On an I-fetch miss, issues one burst read of a 32-byte line to burst memory and collects the four 64-bit beats.
- Replays the line as eight single-word fill beats (fill_valid/fill_addr/fill_data, word placed in its 32-bit slot of a 256-bit bus), critical word first, into the fetch line buffer.
- Sits between the fetch miss logic and the burst memory port.

Parameters:
- LINE_WORDS, 8, 32-bit words per line (fixed; fill_data = LINE_WORDS*32).
- BEAT_BITS, 64, memory beat width.
- BURST_LEN, 4, beats per line burst.

Ports:
- clk  input  1  clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- miss_valid  input  1  fetch miss request.
- miss_addr  input  32  byte address of missing instruction.
- miss_ready  output  1  high only in IDLE; request accepted when miss_valid && miss_ready && !flush.
- flush  input  1  abort current fill (redirect).
- bmem_addr  output  32  line-aligned burst address.
- bmem_read  output  1  burst read request.
- bmem_ready  input  1  memory accepts request this cycle.
- bmem_raddr  input  32  address of returning beat.
- bmem_rdata  input  64  beat data, little-endian words.
- bmem_rvalid  input  1  beat valid.
- fill_valid  output  1  one fill word this cycle.
- fill_addr  output  32  byte address of the fill word.
- fill_data  output  256  word at bits [idx*32 +: 32], all other bits zero.
- fill_done  output  1  pulses with the eighth fill word.
- busy  output  1  state != IDLE.

Behaviour:
- State machine: IDLE, REQ, COLLECT, DRAIN.
- Reset state is IDLE. After reset: miss_ready=1; bmem_read, fill_valid, fill_done and busy = 0; bmem_addr, fill_addr and fill_data = 0; word_valid = 0.
- IDLE:
  - On acceptance, latch line_addr = {miss_addr[31:5],5'b0} and emit_idx = miss_addr[4:2].
  - Clear word_valid[7:0], emit_cnt and beat_cnt; go to REQ.
  - flush is ignored in IDLE, and miss_valid together with flush is not accepted.
- REQ:
  - bmem_read=1 and bmem_addr=line_addr, held stable until bmem_ready=1; then go to COLLECT.
  - flush with bmem_ready=0: go to IDLE and issue no request.
  - flush with bmem_ready=1: go to DRAIN.
  - bmem_addr=0 outside REQ.
- COLLECT, beat capture:
  - On bmem_rvalid, b = bmem_raddr[4:3].
  - Write words 2b (rdata[31:0]) and 2b+1 (rdata[63:32]), set both word_valid bits, beat_cnt++.
  - Beats may arrive in any order, with gaps.
- COLLECT, emission from registered state only (no combinational path from bmem inputs):
  - If word_valid[emit_idx]: fill_valid=1, fill_addr={line_addr[31:5],emit_idx,2'b00}, fill_data=word in slot emit_idx.
  - Then emit_idx=(emit_idx+1) mod 8 (3-bit wrap) and emit_cnt++.
  - If the word is not yet valid, emission stalls: fill_valid=0 and emit_idx is held.
- Latency: a beat in cycle T can produce its word on fill_valid no earlier than T+1.
- Completion: fill_done=1 in the same cycle as the eighth fill_valid; next state IDLE, so miss_ready=1 at T+1.
- flush in COLLECT:
  - fill_valid is forced 0 that cycle.
  - If beats received, including one arriving that cycle, total 4: go to IDLE; otherwise go to DRAIN.
- DRAIN:
  - Discard beats, counting them; go to IDLE in the cycle after the 4th beat.
  - miss_ready=0 and fill_valid=0 throughout.
- bmem_rvalid in IDLE or REQ is a protocol violation: it is ignored, and a simulation assertion is required.
- fill_valid is never asserted while flush=1 or outside COLLECT.
- rst mid-operation: state returns to IDLE next edge; outstanding memory beats are not tracked (memory is reset alongside).

Decomposition:
- Shared package icache_fill_pkg holds:
  - fill_state_t enum (IDLE, REQ, COLLECT, DRAIN);
  - LINE_BYTES=32, WORDS_PER_BEAT=2, WORD_IDX_W=3, BEAT_IDX_W=2.
- One sub-module: fill_line_asm, the 256-bit line register plus word_valid. Inputs: clear, beat write, beat index, rdata. Outputs: word_valid and line data.
- FSM and emission stay in icache_line_fill.

Test Plan:
- Critical word first:
  - Stimulus: miss_addr 0x0000_1014; bmem_ready=1 at once; beats raddr 0x1000/08/10/18, back-to-back.
  - Expect: bmem_addr 0x1000; fill_addr sequence 0x1014,0x1018,0x101C,0x1000,...,0x1010.
  - Expect: first fill_valid the cycle after beat 0x1010; fill_done with 0x1010.
- Request hold: bmem_ready low 3 cycles -> bmem_read=1 and bmem_addr=0x1000 stable all 4 cycles; exactly one acceptance.
- Gapped and out-of-order beats:
  - Stimulus: miss 0x2000; beats 0x2018, gap 2 cycles, 0x2000, 0x2008, 0x2010.
  - Expect: words 0,1 emitted after 0x2000; stall at idx 4 until 0x2010 arrives; 8 words total.
- Flush in COLLECT: flush after 2 beats -> fill_valid 0 from that cycle; remaining 2 beats absorbed; miss_ready=1 the cycle after the 4th beat.
- Flush in REQ with bmem_ready=0 -> IDLE next cycle; no DRAIN; the next miss (0x3000) fills normally.
- Reset: rst mid-COLLECT -> next cycle IDLE, fill_valid=0, word_valid cleared, miss_ready=1.
